// File: rtl/seq_divider_4x4_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// controller state encoding and the full-adder cell used by the subtractor.
package seq_divider_4x4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic ci);
    full_adder = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/seq_divider_4x4_if.sv
// Request/result bundle of the divider: the master issues operands with start,
// the slave (divider) reports busy/done and the registered results.
interface seq_divider_4x4_if
  import seq_divider_4x4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_4x4_ripple_subtractor.sv
// Ripple subtractor: computes i_a - i_b as i_a + ~i_b + 1 through a chain of
// full-adder cells; o_borrow is the inverted final carry.
module ripple_subtractor
  import seq_divider_4x4_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  logic [N:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    assign {w_carry[gi+1], o_diff[gi]} = full_adder(i_a[gi], ~i_b[gi], w_carry[gi]);
  end

  assign o_borrow = ~w_carry[N];

endmodule

// File: rtl/seq_divider_4x4.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done
// handshake, results held in output registers until the next completion.
module seq_divider_4x4
  import seq_divider_4x4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_4x4_if.slave bus
);

  localparam int            CW         = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_count;
  logic             r_dbz_cap;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;

  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH-1:0] w_q_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // {R,Q} moves left as one register; R's top bit is always 0 between steps.
  assign {w_rem_shift, w_q_shift} = {r_rem, r_q} << 1;

  ripple_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .i_a     (w_rem_shift),
    .i_b     ({1'b0, r_d}),
    .o_diff  (w_diff),
    .o_borrow(w_borrow)
  );

  assign w_rem_next = w_borrow ? w_rem_shift : w_diff;
  assign w_q_next   = w_q_shift | {{(WIDTH-1){1'b0}}, ~w_borrow};

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_q       <= {WIDTH{1'b0}};
      r_d       <= {WIDTH{1'b0}};
      r_rem     <= {(WIDTH+1){1'b0}};
      r_count   <= {CW{1'b0}};
      r_dbz_cap <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
      r_quot    <= {WIDTH{1'b0}};
      r_rem_out <= {WIDTH{1'b0}};
    end else begin
      case (r_state)
        IDLE, FINISH: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_q       <= bus.dividend;
            r_d       <= bus.divisor;
            r_rem     <= {(WIDTH+1){1'b0}};
            r_count   <= LAST_COUNT;
            r_dbz_cap <= (bus.divisor == {WIDTH{1'b0}});
            r_busy    <= 1'b1;
            r_state   <= CALC;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          // Outputs load on the last step so done and the results appear together.
          if (r_count == {CW{1'b0}}) begin
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next[WIDTH-1:0];
            r_dbz     <= r_dbz_cap;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= FINISH;
          end else begin
            r_count <= r_count - COUNT_ONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem_out;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_4x4.sv
// Scoreboard bench for seq_divider_4x4: stimulus pushes reference results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_seq_divider_4x4;

  localparam int W  = 4;
  localparam int TO = 40;

  typedef struct {
    int q;
    int r;
    int dbz;
    int due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  seq_divider_4x4_if #(.WIDTH(W)) bus ();

  seq_divider_4x4 #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division; divisor 0 yields all-ones / dividend.
  function automatic exp_t model(input int a, input int b, input int due);
    exp_t e;
    if (b == 0) begin
      e.q   = (1 << W) - 1;
      e.r   = a;
      e.dbz = 1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 0;
    end
    e.due = due;
    return e;
  endfunction

  // Monitor: results and latency on done, busy window otherwise.
  always @(negedge clk) begin
    exp_t e;
    int   eb;
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("quotient", int'(bus.quotient), e.q);
          chk("remainder", int'(bus.remainder), e.r);
          chk("div_by_zero", int'(bus.div_by_zero), e.dbz);
          chk("done_latency", cyc, e.due);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end else begin
        eb = 0;
        if (sb.size() > 0 && cyc >= sb[0].due - W && cyc < sb[0].due) eb = 1;
        chk("busy", int'(bus.busy), eb);
      end
    end
  end

  task automatic do_div(input int a, input int b);
    int g = 0;
    @(negedge clk);
    while (bus.busy && g < TO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TO) chk("idle_timeout", int'(bus.busy), 0);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    sb.push_back(model(a, b, cyc + 1 + W));
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = W'($urandom_range(0, 15));
    bus.divisor  = W'($urandom_range(0, 15));
  endtask

  task automatic wait_idle();
    int g = 0;
    while (sb.size() != 0 && g < TO) begin
      @(negedge clk);
      g++;
    end
    if (g >= TO) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_quotient", int'(bus.quotient), 0);
    chk("rst_remainder", int'(bus.remainder), 0);
    chk("rst_div_by_zero", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    do_div(13, 3);
    wait_idle();
    do_div(15, 15);
    do_div(0, 5);
    do_div(2, 9);
    do_div(7, 0);
    do_div(8, 2);
    wait_idle();

    // Asynchronous reset in the middle of a division.
    do_div(11, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_quotient", int'(bus.quotient), 0);
    chk("mid_rst_remainder", int'(bus.remainder), 0);
    chk("mid_rst_div_by_zero", int'(bus.div_by_zero), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_div(9, 4);
    wait_idle();

    // start held high with operands changing every cycle.
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 0; n < 14; n++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      bus.dividend = W'(a);
      bus.divisor  = W'(b);
      if (!bus.busy) sb.push_back(model(a, b, cyc + 1 + W));
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_idle();

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_div(x, y);
      end
    end
    wait_idle();

    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_div($urandom_range(0, 15), $urandom_range(0, 15));
    end
    wait_idle();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
